// File: rtl/control_unit_pkg.sv
// ============================================================================
// Module : control_unit_pkg
// Brief  : Shared opcode/func constants, control encodings and bundle type
//          for the pipelined control unit.
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

package control_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLT = 4'b0101,
        ALU_SLL = 4'b0110
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_NEXT   = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_BLTZ = 2'b11
    } branch_type_e;

    typedef enum logic [1:0] {
        DB_ALU  = 2'b00,
        DB_MEM  = 2'b01,
        DB_LINK = 2'b10
    } db_src_e;

    // Pure decode result; hazard handling is layered on top in control_unit.
    typedef struct packed {
        logic         reg_dst;
        logic         alu_src_b;
        logic         ext_sel;
        alu_op_e      alu_op;
        branch_type_e branch_type;
        logic         mem_wre;
        logic         mem_read;
        logic         reg_wre;
        db_src_e      db_data_src;
        logic         jump_pc_src;
        logic         is_jump;
        logic         is_halt;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/cu_main_decoder.sv
// ============================================================================
// Module : cu_main_decoder
// Brief  : Pure combinational Opcode/func decode into the control bundle.
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

module cu_main_decoder
    import control_unit_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] func_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o        = '0;
        ctrl_o.alu_op = ALU_ADD;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.reg_dst = 1'b1;
                ctrl_o.reg_wre = 1'b1;
                case (func_i)
                    FN_ADD: ctrl_o.alu_op = ALU_ADD;
                    FN_SUB: ctrl_o.alu_op = ALU_SUB;
                    FN_AND: ctrl_o.alu_op = ALU_AND;
                    FN_OR:  ctrl_o.alu_op = ALU_OR;
                    FN_XOR: ctrl_o.alu_op = ALU_XOR;
                    FN_SLT: ctrl_o.alu_op = ALU_SLT;
                    FN_SLL: ctrl_o.alu_op = ALU_SLL;
                    FN_JR: begin
                        ctrl_o.reg_dst     = 1'b0;
                        ctrl_o.reg_wre     = 1'b0;
                        ctrl_o.is_jump     = 1'b1;
                        ctrl_o.jump_pc_src = 1'b1;
                    end
                    default: begin
                        ctrl_o.reg_dst = 1'b0;
                        ctrl_o.reg_wre = 1'b0;
                    end
                endcase
            end
            OP_J:   ctrl_o.is_jump = 1'b1;
            OP_JAL: begin
                ctrl_o.is_jump     = 1'b1;
                ctrl_o.reg_wre     = 1'b1;
                ctrl_o.db_data_src = DB_LINK;
            end
            OP_BEQ, OP_BNE, OP_BLTZ: begin
                ctrl_o.ext_sel = 1'b1;
                ctrl_o.alu_op  = ALU_SUB;
                ctrl_o.branch_type = (opcode_i == OP_BEQ) ? BR_BEQ :
                                     (opcode_i == OP_BNE) ? BR_BNE : BR_BLTZ;
            end
            OP_LW: begin
                ctrl_o.alu_src_b   = 1'b1;
                ctrl_o.ext_sel     = 1'b1;
                ctrl_o.mem_read    = 1'b1;
                ctrl_o.reg_wre     = 1'b1;
                ctrl_o.db_data_src = DB_MEM;
            end
            OP_SW: begin
                ctrl_o.alu_src_b = 1'b1;
                ctrl_o.ext_sel   = 1'b1;
                ctrl_o.mem_wre   = 1'b1;
            end
            OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl_o.alu_src_b = 1'b1;
                ctrl_o.reg_wre   = 1'b1;
                ctrl_o.ext_sel   = (opcode_i == OP_ADDIU) || (opcode_i == OP_SLTI);
                case (opcode_i)
                    OP_SLTI: ctrl_o.alu_op = ALU_SLT;
                    OP_ANDI: ctrl_o.alu_op = ALU_AND;
                    OP_ORI:  ctrl_o.alu_op = ALU_OR;
                    OP_XORI: ctrl_o.alu_op = ALU_XOR;
                    default: ctrl_o.alu_op = ALU_ADD;
                endcase
            end
            OP_HALT: ctrl_o.is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module : control_unit
// Brief  : Pipeline control: instruction decode plus branch/load-use/halt
//          PC and flush control. Option macro: CU_HALT_LATCH_EN.
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

module control_unit
    import control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] func,
    input  logic       Branch,
    input  logic       ControlSrc,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic       JumpPCSrc,
    output logic       RegDst,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic [3:0] ALUOp,
    output logic [1:0] BranchType,
    output logic       MemWre,
    output logic       MemRead,
    output logic       RegWre,
    output logic [1:0] DBDataSrc,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       EX_MEM_Flush
);

    ctrl_t dec;
    logic  halt_stall;

    cu_main_decoder u_dec (
        .opcode_i (Opcode),
        .func_i   (func),
        .ctrl_o   (dec)
    );

`ifdef CU_HALT_LATCH_EN
    logic halted_q;
    logic halted_d;

    // A halt squashed by a taken branch in MEM never becomes sticky.
    assign halted_d = halted_q | (dec.is_halt & ~Branch);

    always_ff @(posedge clk) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halt_stall = dec.is_halt | (halted_q & ~reset);
`else
    logic unused_clk_reset;
    assign unused_clk_reset = &{1'b0, clk, reset};
    assign halt_stall       = dec.is_halt;
`endif

    assign JumpPCSrc  = dec.jump_pc_src;
    assign RegDst     = dec.reg_dst;
    assign ALUSrcB    = dec.alu_src_b;
    assign ExtSel     = dec.ext_sel;
    assign ALUOp      = dec.alu_op;
    assign BranchType = dec.branch_type;
    assign MemWre     = dec.mem_wre;
    assign MemRead    = dec.mem_read;
    assign RegWre     = dec.reg_wre;
    assign DBDataSrc  = dec.db_data_src;

    // Priority: taken branch > load-use stall > jump/halt in ID.
    always_comb begin
        PCWre        = ~halt_stall;
        PCSrc        = dec.is_jump ? PC_JUMP : PC_NEXT;
        IF_ID_Flush  = dec.is_jump;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        if (Branch) begin
            PCWre        = 1'b1;
            PCSrc        = PC_BRANCH;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
        end else if (ControlSrc) begin
            PCWre        = 1'b0;
            PCSrc        = PC_NEXT;
            IF_ID_Flush  = 1'b0;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module : tb_control_unit
// Brief  : Self-checking bench for control_unit: directed scenarios followed
//          by random stimulus against a table-driven reference model.
// Rev    : 1.0 initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode, func;
    logic       Branch, ControlSrc;
    logic       PCWre, JumpPCSrc, RegDst, ALUSrcB, ExtSel;
    logic [1:0] PCSrc, BranchType, DBDataSrc;
    logic [3:0] ALUOp;
    logic       MemWre, MemRead, RegWre;
    logic       IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush;

    int total = 0;
    int bad   = 0;
    logic model_halted = 1'b0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk          (clk),
        .reset        (reset),
        .Opcode       (Opcode),
        .func         (func),
        .Branch       (Branch),
        .ControlSrc   (ControlSrc),
        .PCWre        (PCWre),
        .PCSrc        (PCSrc),
        .JumpPCSrc    (JumpPCSrc),
        .RegDst       (RegDst),
        .ALUSrcB      (ALUSrcB),
        .ExtSel       (ExtSel),
        .ALUOp        (ALUOp),
        .BranchType   (BranchType),
        .MemWre       (MemWre),
        .MemRead      (MemRead),
        .RegWre       (RegWre),
        .DBDataSrc    (DBDataSrc),
        .IF_ID_Flush  (IF_ID_Flush),
        .ID_EX_Flush  (ID_EX_Flush),
        .EX_MEM_Flush (EX_MEM_Flush)
    );

    // Field order: PCWre PCSrc JumpPCSrc RegDst ALUSrcB ExtSel ALUOp
    //              BranchType MemWre MemRead RegWre DBDataSrc IF ID EX flushes
    function automatic logic [21:0] observed();
        return {PCWre, PCSrc, JumpPCSrc, RegDst, ALUSrcB, ExtSel, ALUOp,
                BranchType, MemWre, MemRead, RegWre, DBDataSrc,
                IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush};
    endfunction

    function automatic logic [21:0] model(input logic [5:0] op, input logic [5:0] fn,
                                          input logic br, input logic cs,
                                          input logic rst, input logic hlt);
        logic       pcwre = 1'b1, jsrc = 1'b0, rdst = 1'b0, srcb = 1'b0, ext = 1'b0;
        logic [1:0] pcsrc = 2'd0, bt = 2'd0, db = 2'd0;
        logic [3:0] aluop = 4'd0;
        logic       mw = 1'b0, mr = 1'b0, rw = 1'b0, f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: begin rdst = 1; rw = 1; aluop = 4'd0; end
                    6'h22: begin rdst = 1; rw = 1; aluop = 4'd1; end
                    6'h24: begin rdst = 1; rw = 1; aluop = 4'd2; end
                    6'h25: begin rdst = 1; rw = 1; aluop = 4'd3; end
                    6'h26: begin rdst = 1; rw = 1; aluop = 4'd4; end
                    6'h2A: begin rdst = 1; rw = 1; aluop = 4'd5; end
                    6'h00: begin rdst = 1; rw = 1; aluop = 4'd6; end
                    6'h08: begin pcsrc = 2'b10; jsrc = 1; f1 = 1; end
                    default: ;
                endcase
            end
            6'h02: begin pcsrc = 2'b10; f1 = 1; end
            6'h03: begin pcsrc = 2'b10; f1 = 1; rw = 1; db = 2'b10; end
            6'h04: begin ext = 1; aluop = 4'd1; bt = 2'b01; end
            6'h05: begin ext = 1; aluop = 4'd1; bt = 2'b10; end
            6'h01: begin ext = 1; aluop = 4'd1; bt = 2'b11; end
            6'h23: begin srcb = 1; ext = 1; mr = 1; rw = 1; db = 2'b01; end
            6'h2B: begin srcb = 1; ext = 1; mw = 1; end
            6'h09: begin srcb = 1; rw = 1; ext = 1; aluop = 4'd0; end
            6'h0A: begin srcb = 1; rw = 1; ext = 1; aluop = 4'd5; end
            6'h0C: begin srcb = 1; rw = 1; aluop = 4'd2; end
            6'h0D: begin srcb = 1; rw = 1; aluop = 4'd3; end
            6'h0E: begin srcb = 1; rw = 1; aluop = 4'd4; end
            6'h3F: pcwre = 0;
            default: ;
        endcase
`ifdef CU_HALT_LATCH_EN
        if (hlt && !rst) pcwre = 0;
`else
        if (hlt && rst) pcwre = pcwre;
`endif
        if (br) begin
            pcwre = 1; pcsrc = 2'b01; f1 = 1; f2 = 1; f3 = 1;
        end else if (cs) begin
            pcwre = 0; pcsrc = 2'b00; f1 = 0; f2 = 1; f3 = 0;
        end
        return {pcwre, pcsrc, jsrc, rdst, srcb, ext, aluop, bt, mw, mr, rw, db, f1, f2, f3};
    endfunction

    // Apply inputs just after a rising edge, check on the falling edge,
    // then advance the halt model across the next rising edge.
    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic br, input logic cs, input logic rst);
        logic [21:0] exp_v;
        Opcode = op; func = fn; Branch = br; ControlSrc = cs; reset = rst;
        @(negedge clk);
        exp_v = model(op, fn, br, cs, rst, model_halted);
        total++;
        assert (observed() === exp_v) else begin
            bad++;
            $error("FAIL %s op=%h fn=%h br=%0b cs=%0b rst=%0b observed=%h expected=%h",
                   tag, op, fn, br, cs, rst, observed(), exp_v);
        end
        @(posedge clk);
        if (rst) model_halted = 1'b0;
        else if (op == 6'h3F && !br) model_halted = 1'b1;
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp_b);
        total++;
        assert (obs === exp_b) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_b);
        end
    endtask

    initial begin
        logic [5:0] ops [15];
        logic [5:0] fns [9];
        logic [5:0] op, fn;
        ops = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h08, 6'h3F};
        Opcode = 6'h00; func = 6'h20; Branch = 0; ControlSrc = 0; reset = 1;
        @(posedge clk); #1;

        step("reset_add",  6'h00, 6'h20, 0, 0, 1);
        step("add",        6'h00, 6'h20, 0, 0, 0);
        check_bit("add_pcwre", PCWre, 1'b1);
        step("jal",        6'h03, 6'h00, 0, 0, 0);
        step("jr",         6'h00, 6'h08, 0, 0, 0);
        step("ori",        6'h0D, 6'h00, 0, 0, 0);
        step("lw",         6'h23, 6'h00, 0, 0, 0);
        step("add_branch", 6'h00, 6'h20, 1, 0, 0);
        step("add_stall",  6'h00, 6'h20, 0, 1, 0);
        step("j_stall",    6'h02, 6'h00, 0, 1, 0);
        step("j_branch",   6'h02, 6'h00, 1, 1, 0);
        step("undef_op",   6'h3E, 6'h00, 0, 0, 0);
        step("undef_fn",   6'h00, 6'h3F, 0, 0, 0);
        step("halt_br",    6'h3F, 6'h00, 1, 0, 0);
        step("after_hbr",  6'h00, 6'h20, 0, 0, 0);
        check_bit("after_hbr_pcwre", PCWre, 1'b1);
        step("halt",       6'h3F, 6'h00, 0, 0, 0);
        step("add_after_halt", 6'h00, 6'h20, 0, 0, 0);
`ifdef CU_HALT_LATCH_EN
        check_bit("halt_held", PCWre, 1'b0);
        step("halted_branch", 6'h00, 6'h20, 1, 0, 0);
`endif
        step("reset_clear", 6'h00, 6'h20, 0, 0, 1);
        step("post_reset",  6'h00, 6'h20, 0, 0, 0);
        check_bit("post_reset_pcwre", PCWre, 1'b1);

        for (int i = 0; i < 300; i++) begin
            op = (($urandom_range(0, 9) == 0) ? 6'h3F :
                  ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 14)]);
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 8)];
            step("random", op, fn, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
